// File: rtl/qea_host_ctrl_pkg.sv
// Shared definitions for the QEA host controller: job FSM states and the
// fixed-point 1.0 amplitude used to seed the |0...0> basis state.
package qea_host_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_CTX,
        S_LOAD_STATE,
        S_START,
        S_RUN,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_OUT,
        S_DONE
    } qea_state_e;

    localparam int unsigned QEA_NUM_FRAC_BIT = 30;

    // 1.0 in a fixed-point format with frac_bits fraction bits.
    function automatic logic [63:0] amp_one(input int unsigned frac_bits);
        return 64'd1 << frac_bits;
    endfunction

endpackage

// File: rtl/qea_host_ctrl.sv
// Host-side job sequencer for the QEA: loads gate context, seeds the state
// vector, starts the accelerator, times the run and streams the state back.
module qea_host_ctrl
    import qea_host_ctrl_pkg::*;
#(
    parameter int unsigned PE_NUM_WIDTH            = 2,
    parameter int unsigned PE_NUM                  = 4,
    parameter int unsigned DATA_WIDTH              = 32,
    parameter int unsigned MAX_QBIT_WIDTH          = 6,
    parameter int unsigned STATE_DATA_WIDTH        = 2 * DATA_WIDTH,
    parameter int unsigned STATE_ADDR_WIDTH        = 16,
    parameter int unsigned GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int unsigned GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int unsigned NUM_FRAC_BIT            = QEA_NUM_FRAC_BIT
) (
    input  logic                                 clk,
    input  logic                                 rst_n,

    input  logic                                 i_cmd_valid,
    output logic                                 o_cmd_ready,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_cmd_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_cmd_ins_num,

    input  logic                                 i_ctx_valid,
    output logic                                 o_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,

    output logic                                 o_res_valid,
    input  logic                                 i_res_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_res_data,
    output logic                                 o_res_last,

    output logic                                 o_busy,
    output logic                                 o_done,
    output logic [31:0]                          o_cycle_cnt,

    output logic                                 o_qea_start,
    output logic                                 o_qea_ctx_en,
    output logic                                 o_qea_ctx_wea,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_qea_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_qea_ctx_data,

    output logic                                 o_qea_state_ena,
    output logic                                 o_qea_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_qea_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_qea_state_dina,

    input  logic                                 i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout
);

    localparam int unsigned WORD_W = PE_NUM * STATE_DATA_WIDTH;

    localparam logic [MAX_QBIT_WIDTH-1:0]          PEW_Q    = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    localparam logic [STATE_ADDR_WIDTH-1:0]        ADDR_ONE = STATE_ADDR_WIDTH'(1);
    localparam logic [GATE_CONTEXT_ADDR_WIDTH-1:0] CTX_ONE  = GATE_CONTEXT_ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0]              AMP_ONE  = DATA_WIDTH'(amp_one(NUM_FRAC_BIT));

    // Seed word: real part of the top PE lane is 1.0, everything else zero.
    localparam logic [WORD_W-1:0] INIT_WORD = {AMP_ONE, {(WORD_W - DATA_WIDTH){1'b0}}};

    qea_state_e                           state_q, state_d;
    logic [MAX_QBIT_WIDTH-1:0]            qbit_q, qbit_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ins_q, ins_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_cnt_q, ctx_cnt_d;
    logic [STATE_ADDR_WIDTH-1:0]          addr_cnt_q, addr_cnt_d;
    logic [31:0]                          cycle_cnt_q, cycle_cnt_d;
    logic [WORD_W-1:0]                    res_data_q, res_data_d;
    logic                                 ctx_en_q, ctx_en_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_addr_q, ctx_addr_d;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0]   ctx_data_q, ctx_data_d;

    logic [MAX_QBIT_WIDTH-1:0]            depth_shift;
    logic [STATE_ADDR_WIDTH-1:0]          last_addr;
    logic                                 addr_at_last;

    // Last state address D-1; shifts past the address width wrap to all-ones,
    // which is the correct saturated depth for oversized qubit counts.
    always_comb begin
        depth_shift = qbit_q - PEW_Q;
        last_addr   = '0;
        if (qbit_q > PEW_Q) begin
            last_addr = (ADDR_ONE << depth_shift) - ADDR_ONE;
        end
    end

    assign addr_at_last = (addr_cnt_q == last_addr);

    // NOTE: every output of this block gets a default first so no path through
    // the case statement leaves a variable unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        qbit_d      = qbit_q;
        ins_d       = ins_q;
        ctx_cnt_d   = ctx_cnt_q;
        addr_cnt_d  = addr_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        res_data_d  = res_data_q;
        ctx_en_d    = 1'b0;
        ctx_addr_d  = ctx_addr_q;
        ctx_data_d  = ctx_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    qbit_d     = i_cmd_qbit_num;
                    ins_d      = i_cmd_ins_num;
                    ctx_cnt_d  = '0;
                    addr_cnt_d = '0;
                    state_d    = (i_cmd_ins_num == '0) ? S_LOAD_STATE : S_LOAD_CTX;
                end
            end
            S_LOAD_CTX: begin
                if (i_ctx_valid) begin
                    ctx_en_d   = 1'b1;
                    ctx_addr_d = ctx_cnt_q;
                    ctx_data_d = i_ctx_data;
                    ctx_cnt_d  = ctx_cnt_q + CTX_ONE;
                    if (ctx_cnt_q == ins_q - CTX_ONE) begin
                        state_d = S_LOAD_STATE;
                    end
                end
            end
            S_LOAD_STATE: begin
                addr_cnt_d = addr_cnt_q + ADDR_ONE;
                if (addr_at_last) begin
                    addr_cnt_d = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                cycle_cnt_d = '0;
                state_d     = S_RUN;
            end
            S_RUN: begin
                if (cycle_cnt_q != '1) begin
                    cycle_cnt_d = cycle_cnt_q + 32'd1;
                end
                if (i_qea_complete) begin
                    state_d = S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                res_data_d = i_qea_state_dout;
                state_d    = S_RD_OUT;
            end
            S_RD_OUT: begin
                if (i_res_ready) begin
                    if (addr_at_last) begin
                        state_d = S_DONE;
                    end else begin
                        addr_cnt_d = addr_cnt_q + ADDR_ONE;
                        state_d    = S_RD_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: every datapath register is reset, not just the FSM, so an aborted
    // job leaves no stale context write or result word on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            qbit_q      <= '0;
            ins_q       <= '0;
            ctx_cnt_q   <= '0;
            addr_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            res_data_q  <= '0;
            ctx_en_q    <= 1'b0;
            ctx_addr_q  <= '0;
            ctx_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            qbit_q      <= qbit_d;
            ins_q       <= ins_d;
            ctx_cnt_q   <= ctx_cnt_d;
            addr_cnt_q  <= addr_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            res_data_q  <= res_data_d;
            ctx_en_q    <= ctx_en_d;
            ctx_addr_q  <= ctx_addr_d;
            ctx_data_q  <= ctx_data_d;
        end
    end

    // Ready is masked by reset so it only rises once the block is released.
    assign o_cmd_ready       = rst_n & (state_q == S_IDLE);
    assign o_ctx_ready       = (state_q == S_LOAD_CTX);

    assign o_res_valid       = (state_q == S_RD_OUT);
    assign o_res_last        = (state_q == S_RD_OUT) & addr_at_last;
    assign o_res_data        = res_data_q;

    assign o_busy            = (state_q != S_IDLE);
    assign o_done            = (state_q == S_DONE);
    assign o_cycle_cnt       = cycle_cnt_q;

    assign o_qea_start       = (state_q == S_START);
    assign o_qea_qbit_num    = qbit_q;
    assign o_qea_ctx_en      = ctx_en_q;
    assign o_qea_ctx_wea     = ctx_en_q;
    assign o_qea_ctx_addr    = ctx_addr_q;
    assign o_qea_ctx_data    = ctx_data_q;

    assign o_qea_state_ena   = (state_q == S_LOAD_STATE) | (state_q == S_RD_ISSUE);
    assign o_qea_state_wea   = (state_q == S_LOAD_STATE);
    assign o_qea_state_addra = o_qea_state_ena ? addr_cnt_q : '0;
    assign o_qea_state_dina  = ((state_q == S_LOAD_STATE) && (addr_cnt_q == '0)) ? INIT_WORD : '0;

endmodule

// File: tb/tb_qea_host_ctrl.sv
// Self-checking bench for qea_host_ctrl: randomized jobs against a queue-based
// job model, with the bench acting as the QEA context/state memories.
module tb_qea_host_ctrl;

    localparam int LW = 256;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_cmd_valid = 1'b0;
    logic           o_cmd_ready;
    logic [5:0]     i_cmd_qbit_num = '0;
    logic [15:0]    i_cmd_ins_num = '0;
    logic           i_ctx_valid = 1'b0;
    logic           o_ctx_ready;
    logic [63:0]    i_ctx_data = '0;
    logic           o_res_valid;
    logic           i_res_ready = 1'b0;
    logic [LW-1:0]  o_res_data;
    logic           o_res_last;
    logic           o_busy;
    logic           o_done;
    logic [31:0]    o_cycle_cnt;
    logic           o_qea_start;
    logic           o_qea_ctx_en;
    logic           o_qea_ctx_wea;
    logic [5:0]     o_qea_qbit_num;
    logic [15:0]    o_qea_ctx_addr;
    logic [63:0]    o_qea_ctx_data;
    logic           o_qea_state_ena;
    logic           o_qea_state_wea;
    logic [15:0]    o_qea_state_addra;
    logic [LW-1:0]  o_qea_state_dina;
    logic           i_qea_complete = 1'b0;
    logic [LW-1:0]  i_qea_state_dout = '0;

    always #5 clk = ~clk;

    qea_host_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_cmd_valid       (i_cmd_valid),
        .o_cmd_ready       (o_cmd_ready),
        .i_cmd_qbit_num    (i_cmd_qbit_num),
        .i_cmd_ins_num     (i_cmd_ins_num),
        .i_ctx_valid       (i_ctx_valid),
        .o_ctx_ready       (o_ctx_ready),
        .i_ctx_data        (i_ctx_data),
        .o_res_valid       (o_res_valid),
        .i_res_ready       (i_res_ready),
        .o_res_data        (o_res_data),
        .o_res_last        (o_res_last),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_cycle_cnt       (o_cycle_cnt),
        .o_qea_start       (o_qea_start),
        .o_qea_ctx_en      (o_qea_ctx_en),
        .o_qea_ctx_wea     (o_qea_ctx_wea),
        .o_qea_qbit_num    (o_qea_qbit_num),
        .o_qea_ctx_addr    (o_qea_ctx_addr),
        .o_qea_ctx_data    (o_qea_ctx_data),
        .o_qea_state_ena   (o_qea_state_ena),
        .o_qea_state_wea   (o_qea_state_wea),
        .o_qea_state_addra (o_qea_state_addra),
        .o_qea_state_dina  (o_qea_state_dina),
        .i_qea_complete    (i_qea_complete),
        .i_qea_state_dout  (i_qea_state_dout)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand256();
        logic [LW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Number of state words for a job: 2^(qbit-2) with four PEs, minimum one.
    function automatic int exp_depth(input int qbit);
        return (qbit <= 2) ? 1 : (2 ** (qbit - 2));
    endfunction

    function automatic logic [LW-1:0] seed_word();
        logic [LW-1:0] w;
        w = '0;
        w[255:224] = 32'h4000_0000;
        return w;
    endfunction

    typedef struct {
        logic [15:0]   addr;
        logic [LW-1:0] data;
        logic          we;
    } wr_t;

    wr_t           ctx_q[$];
    wr_t           st_q[$];
    logic [LW-1:0] mem[int];
    int            rd_count = 0;

    // Write/read observer: logs every memory-port transaction the DUT makes.
    initial forever begin
        @(negedge clk);
        if (o_qea_ctx_en)
            ctx_q.push_back('{addr: o_qea_ctx_addr, data: LW'(o_qea_ctx_data), we: o_qea_ctx_wea});
        if (o_qea_state_ena && o_qea_state_wea) begin
            st_q.push_back('{addr: o_qea_state_addra, data: o_qea_state_dina, we: 1'b1});
            mem[int'(o_qea_state_addra)] = o_qea_state_dina;
        end
        if (o_qea_state_ena && !o_qea_state_wea) rd_count++;
    end

    // State RAM read port: one-cycle latency, garbage whenever no read was issued.
    initial forever begin
        logic rd;
        int   a;
        @(negedge clk);
        rd = o_qea_state_ena && !o_qea_state_wea;
        a  = int'(o_qea_state_addra);
        @(posedge clk);
        #1;
        i_qea_state_dout = (rd && mem.exists(a)) ? mem[a] : rand256();
    end

    task automatic wait_cmd_ready();
        int guard = 0;
        while (!o_cmd_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_ready_idle", LW'(o_cmd_ready), 1);
    endtask

    task automatic run_job(input int qbit, input int ins, input int ctx_mode,
                           input int run_cycles, input int stall_beat);
        int          d;
        int          idx;
        int          guard;
        int          rd_before;
        int          stall_left;
        bit          got;
        logic [63:0] words[$];
        logic        v;

        d = exp_depth(qbit);
        for (int i = 0; i < ins; i++) words.push_back({$urandom, $urandom});

        wait_cmd_ready();
        ctx_q.delete();
        st_q.delete();
        mem.delete();
        rd_count = 0;

        i_cmd_valid    = 1'b1;
        i_cmd_qbit_num = 6'(qbit);
        i_cmd_ins_num  = 16'(ins);
        @(negedge clk);
        i_cmd_valid    = 1'b0;
        i_cmd_qbit_num = 6'($urandom);
        i_cmd_ins_num  = 16'($urandom);
        check("busy_after_cmd", LW'(o_busy), 1);
        check("qbit_latched", LW'(o_qea_qbit_num), LW'(qbit));

        idx   = 0;
        guard = 0;
        while (idx < ins && guard < 4 * ins + 100) begin
            case (ctx_mode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            i_ctx_valid    = v;
            i_ctx_data     = v ? words[idx] : {$urandom, $urandom};
            i_qea_complete = 1'($urandom_range(0, 1));
            if (v && o_ctx_ready) idx++;
            @(negedge clk);
            guard++;
        end
        i_ctx_valid = 1'b0;
        check("ctx_all_accepted", LW'(idx), LW'(ins));

        guard = 0;
        while (!o_qea_start && guard < 2000) begin
            i_qea_complete = 1'($urandom_range(0, 1));
            @(negedge clk);
            guard++;
        end
        check("start_seen", LW'(o_qea_start), 1);
        i_qea_complete = 1'($urandom_range(0, 1));
        @(negedge clk);
        i_qea_complete = 1'b0;
        check("start_one_cycle", LW'(o_qea_start), 0);

        check("ctx_wr_count", LW'(ctx_q.size()), LW'(ins));
        for (int i = 0; i < ins && i < ctx_q.size(); i++) begin
            check("ctx_wr_addr", LW'(ctx_q[i].addr), LW'(i));
            check("ctx_wr_data", ctx_q[i].data, LW'(words[i]));
            check("ctx_wr_wea", LW'(ctx_q[i].we), 1);
        end
        check("st_wr_count", LW'(st_q.size()), LW'(d));
        for (int j = 0; j < d && j < st_q.size(); j++) begin
            check("st_wr_addr", LW'(st_q[j].addr), LW'(j));
            check("st_wr_data", st_q[j].data, (j == 0) ? seed_word() : '0);
        end

        for (int k = 0; k < d; k++) mem[k] = rand256();
        repeat (run_cycles - 1) @(negedge clk);
        i_qea_complete = 1'b1;
        @(negedge clk);
        i_qea_complete = 1'b0;

        for (int k = 0; k < d; k++) begin
            got        = 1'b0;
            guard      = 0;
            stall_left = (k == stall_beat) ? 10 : 0;
            rd_before  = 0;
            while (!got && guard < 200) begin
                i_qea_complete = 1'($urandom_range(0, 1));
                i_res_ready    = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
                if (o_res_valid && stall_left > 0) begin
                    if (stall_left == 10) rd_before = rd_count;
                    check("stall_data_stable", o_res_data, mem[k]);
                    stall_left--;
                    if (stall_left == 0) check("stall_no_extra_read", LW'(rd_count), LW'(rd_before));
                end
                if (o_res_valid && i_res_ready) begin
                    if (k == 0) check("cycle_cnt", LW'(o_cycle_cnt), LW'(run_cycles));
                    check("res_data", o_res_data, mem[k]);
                    check("res_last", LW'(o_res_last), LW'(k == d - 1));
                    got = 1'b1;
                end
                @(negedge clk);
                guard++;
            end
            if (!got) check("res_beat_timeout", 0, 1);
        end
        i_res_ready    = 1'b0;
        i_qea_complete = 1'b0;
        check("read_count", LW'(rd_count), LW'(d));

        check("done_pulse", LW'(o_done), 1);
        @(negedge clk);
        check("done_one_cycle", LW'(o_done), 0);
        check("busy_cleared", LW'(o_busy), 0);
    endtask

    function automatic logic [LW-1:0] outs_nonzero();
        return LW'({o_cmd_ready, o_ctx_ready, o_res_valid, o_res_last, o_busy, o_done,
                    o_qea_start, o_qea_ctx_en, o_qea_ctx_wea, o_qea_state_ena, o_qea_state_wea,
                    |o_res_data, |o_cycle_cnt, |o_qea_qbit_num, |o_qea_ctx_addr,
                    |o_qea_ctx_data, |o_qea_state_addra, |o_qea_state_dina});
    endfunction

    task automatic reset_mid_run();
        int guard;
        wait_cmd_ready();
        i_cmd_valid    = 1'b1;
        i_cmd_qbit_num = 6'd4;
        i_cmd_ins_num  = 16'd3;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        i_ctx_valid = 1'b1;
        i_ctx_data  = 64'hDEAD_BEEF_1234_5678;
        repeat (3) @(negedge clk);
        i_ctx_valid = 1'b0;
        guard = 0;
        while (!o_qea_start && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("rst_run_start_seen", LW'(o_qea_start), 1);
        repeat (6) @(negedge clk);
        check("rst_run_counting", LW'(o_cycle_cnt != 0), 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_run_outputs", outs_nonzero(), '0);
        @(negedge clk);
        check("rst_held_outputs", outs_nonzero(), '0);
        rst_n = 1'b1;
        #1;
        check("rst_release_cmd_ready", LW'(o_cmd_ready), 1);
        check("rst_release_busy", LW'(o_busy), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", outs_nonzero(), '0);
        rst_n = 1'b1;
        #1;
        check("reset_release_cmd_ready", LW'(o_cmd_ready), 1);
        check("reset_cycle_cnt", LW'(o_cycle_cnt), 0);
        @(negedge clk);

        run_job(6, 589, 0, 30, -1);
        run_job(5, 37, 1, 20, -1);
        run_job(2, 0, 0, 5, -1);
        run_job(6, 8, 2, 100, 3);
        reset_mid_run();
        run_job(3, 5, 2, 12, 0);

        for (int n = 0; n < 8; n++) begin
            int q;
            q = $urandom_range(0, 6);
            run_job(q, $urandom_range(0, 40), $urandom_range(0, 2), $urandom_range(1, 60),
                    ($urandom_range(0, 1) != 0) ? $urandom_range(0, exp_depth(q) - 1) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qea_host_ctrl.md
QEA_HOST_CTRL -- requirements
Module: qea_host_ctrl

Interface
REQ-001 SHALL have these parameters (name, default, meaning): PE_NUM_WIDTH, 2, log2 of PE count.
REQ-002 PE_NUM, 4, number of processing elements; DATA_WIDTH, 32, one real or imaginary fixed-point part.
REQ-003 MAX_QBIT_WIDTH, 6, qubit-count field width; STATE_DATA_WIDTH, 2*DATA_WIDTH, one complex amplitude; STATE_ADDR_WIDTH, 16.
REQ-004 GATE_CONTEXT_DATA_WIDTH, 64, one context word; GATE_CONTEXT_ADDR_WIDTH, 16; NUM_FRAC_BIT, 30, fraction bits of amplitudes.
REQ-005 SHALL have one clock, clk; reset rst_n is asynchronous and active-low.
REQ-006 SHALL have these ports (name, direction, width, meaning): clk, in, 1, clock.
REQ-007 rst_n, in, 1, asynchronous active-low reset.
REQ-008 i_cmd_valid, in, 1; o_cmd_ready, out, 1: job command handshake.
REQ-009 i_cmd_qbit_num, in, MAX_QBIT_WIDTH; i_cmd_ins_num, in, GATE_CONTEXT_ADDR_WIDTH: job qubit count and context word count.
REQ-010 i_ctx_valid, in, 1; o_ctx_ready, out, 1; i_ctx_data, in, GATE_CONTEXT_DATA_WIDTH: context word stream.
REQ-011 o_res_valid, out, 1; i_res_ready, in, 1; o_res_data, out, PE_NUM*STATE_DATA_WIDTH; o_res_last, out, 1: result stream.
REQ-012 o_busy, out, 1; o_done, out, 1, one-cycle pulse; o_cycle_cnt, out, 32, clk cycles from start to complete.
REQ-013 o_qea_start, o_qea_ctx_en, o_qea_ctx_wea, out, 1 each; o_qea_qbit_num, out, MAX_QBIT_WIDTH.
REQ-014 o_qea_ctx_addr, out, GATE_CONTEXT_ADDR_WIDTH; o_qea_ctx_data, out, GATE_CONTEXT_DATA_WIDTH.
REQ-015 o_qea_state_ena, o_qea_state_wea, out, 1 each; o_qea_state_addra, out, STATE_ADDR_WIDTH; o_qea_state_dina, out, PE_NUM*STATE_DATA_WIDTH.
REQ-016 i_qea_complete, in, 1; i_qea_state_dout, in, PE_NUM*STATE_DATA_WIDTH: accelerator status and state read data.

Function
REQ-017 SHALL implement FSM IDLE->LOAD_CTX->LOAD_STATE->START->RUN->RD_ISSUE->RD_WAIT->RD_OUT->DONE->IDLE.
REQ-018 o_cmd_ready SHALL be 1 only in IDLE; a command handshake latches qbit_num and ins_num and sets o_busy.
REQ-019 If ins_num==0, IDLE SHALL go directly to LOAD_STATE.
REQ-020 In LOAD_CTX, o_ctx_ready=1; each accepted word drives ctx_en=ctx_wea=1 with addr 0,1,...,ins_num-1 on the next cycle; exit after word ins_num-1.
REQ-021 In LOAD_STATE, depth D=2^(qbit_num-PE_NUM_WIDTH), or 1 if qbit_num<=PE_NUM_WIDTH; write addr 0..D-1, one per cycle.
REQ-022 The addr 0 word SHALL have only the top PE lane real part = 1<<NUM_FRAC_BIT (0x40000000); all other words SHALL be zero.
REQ-023 START SHALL assert o_qea_start for exactly one cycle, then clear o_cycle_cnt and enter RUN.
REQ-024 In RUN, o_cycle_cnt SHALL increment each cycle, saturating at all-ones; i_qea_complete=1 exits to RD_ISSUE; complete SHALL be ignored in all other states.
REQ-025 Readback SHALL drive state_ena=1, state_wea=0, addr k; read data is valid 1 cycle later (RD_WAIT) and is registered into o_res_data.
REQ-026 RD_OUT SHALL hold o_res_valid and o_res_data stable until i_res_ready; o_res_last=1 for k=D-1; the next read issues after the handshake.
REQ-027 DONE SHALL pulse o_done for one cycle and clear o_busy on return to IDLE.
REQ-028 o_qea_qbit_num SHALL equal the latched qbit_num; all QEA enables SHALL be 0 outside their owning states.

Reset
REQ-029 On rst_n low, SHALL enter IDLE immediately, even mid-job.
REQ-030 On reset, all outputs SHALL be 0 except o_cmd_ready, which becomes 1 once rst_n is high.
REQ-031 o_cycle_cnt SHALL reset to 0; no partial write may persist beyond the reset edge.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and the 1.0 amplitude constant (1<<NUM_FRAC_BIT).
REQ-033 SHALL be a single module with no sub-module; depth computation is local combinational logic.

Verification
REQ-034 qbit=6, ins=589, ctx stream with no gaps: 589 ctx writes at addr 0..588, then 16 state writes, addr 0 = 0x40000000_00000000 in the top lane.
REQ-035 ctx_valid toggling every other cycle: addresses stay contiguous and no word is dropped or duplicated.
REQ-036 ins=0, qbit=2: no ctx writes; exactly 1 state write; start pulse lasts 1 cycle.
REQ-037 complete asserted 100 cycles after start: o_cycle_cnt=100 (+/-1 per documented edge); 16 result beats; o_res_last on beat 16.
REQ-038 i_res_ready held low for 10 cycles: o_res_data stable, no extra reads issued.
REQ-039 rst_n low during RUN: all outputs 0 immediately; a new command is accepted after release.
